// File: rtl/rv_fetch.sv
// rtl/rv_fetch.sv - instruction fetch stage: PC generation, pipelined imem reads, 2-entry fetch buffer, redirect flush
module rv_fetch #(
    parameter logic [31:0] g_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic        im_busy_i,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o,
    input  logic        f_stall_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_pc_bra_i
);

    // next fetch address
    logic [31:0] r_pc_next;

    // FIFO of issued PCs whose responses are still outstanding
    logic [31:0] r_pcq_pc [2];
    logic        r_pcq_rd;
    logic        r_pcq_wr;
    logic [1:0]  r_pcq_cnt;

    // FIFO of {pc, ir} pairs waiting for decode
    logic [31:0] r_oq_pc [2];
    logic [31:0] r_oq_ir [2];
    logic        r_oq_rd;
    logic        r_oq_wr;
    logic [1:0]  r_oq_cnt;

    // responses still in flight from a flushed path
    logic [1:0]  r_drop_cnt;

    logic [2:0]  w_credit;
    logic        w_issue;
    logic        w_oq_pop;
    logic        w_oq_push;
    logic        w_resp_drop;
    logic        w_resp_take;
    logic        w_resp_any;
    logic [31:0] w_pcq_head;
    logic [31:0] w_target;
    logic [2:0]  w_drop_sum;

    assign f_valid_o = (r_oq_cnt != 2'd0);
    assign f_ir_o    = r_oq_ir[r_oq_rd];
    assign f_pc_o    = r_oq_pc[r_oq_rd];
    assign w_oq_pop  = f_valid_o && !f_stall_i;

    // Slots are counted after this cycle's decode pop so that a 1-cycle
    // memory sustains one instruction per cycle; every outstanding request
    // (live or to-be-dropped) still owns a buffer slot when it returns.
    assign w_credit  = 3'(r_pcq_cnt) + 3'(r_oq_cnt) + 3'(r_drop_cnt) - 3'(w_oq_pop);

    // reset gates the request combinationally so it drops the instant reset asserts
    assign im_rd_o   = rst_n_i && !x_bra_i && (w_credit < 3'd2);
    assign im_addr_o = r_pc_next;
    assign w_issue   = im_rd_o && !im_busy_i;

    // a response either belongs to a flushed path or to the pcq head;
    // a response with neither is a protocol error and is ignored
    assign w_resp_drop = im_valid_i && (r_drop_cnt != 2'd0);
    assign w_resp_take = im_valid_i && (r_drop_cnt == 2'd0) && (r_pcq_cnt != 2'd0);
    assign w_resp_any  = w_resp_drop || w_resp_take;
    assign w_oq_push   = w_resp_take && !x_bra_i;
    assign w_pcq_head  = r_pcq_pc[r_pcq_rd];

    assign w_target    = x_pc_bra_i & 32'hFFFF_FFFC;

    // on redirect, everything still outstanding after this cycle's response must be discarded
    assign w_drop_sum  = 3'(r_drop_cnt) + 3'(r_pcq_cnt) - 3'(w_resp_any);

    // next-PC register: redirect target or sequential +4 on each accepted request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc_next <= g_RESET_VECTOR;
        end else if (x_bra_i) begin
            r_pc_next <= w_target;
        end else if (w_issue) begin
            r_pc_next <= r_pc_next + 32'd4;
        end
    end

    // issued-PC queue: push on acceptance, pop on a live response, flush on redirect
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                r_pcq_pc[i] <= 32'd0;
            end
            r_pcq_rd  <= 1'b0;
            r_pcq_wr  <= 1'b0;
            r_pcq_cnt <= 2'd0;
        end else if (x_bra_i) begin
            r_pcq_rd  <= 1'b0;
            r_pcq_wr  <= 1'b0;
            r_pcq_cnt <= 2'd0;
        end else begin
            if (w_issue) begin
                r_pcq_pc[r_pcq_wr] <= r_pc_next;
                r_pcq_wr           <= ~r_pcq_wr;
            end
            if (w_resp_take) begin
                r_pcq_rd <= ~r_pcq_rd;
            end
            case ({w_issue, w_resp_take})
                2'b10:   r_pcq_cnt <= r_pcq_cnt + 2'd1;
                2'b01:   r_pcq_cnt <= r_pcq_cnt - 2'd1;
                default: r_pcq_cnt <= r_pcq_cnt;
            endcase
        end
    end

    // output queue: pair response with its PC, pop when decode takes it, flush on redirect
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                r_oq_pc[i] <= 32'd0;
                r_oq_ir[i] <= 32'd0;
            end
            r_oq_rd  <= 1'b0;
            r_oq_wr  <= 1'b0;
            r_oq_cnt <= 2'd0;
        end else if (x_bra_i) begin
            r_oq_rd  <= 1'b0;
            r_oq_wr  <= 1'b0;
            r_oq_cnt <= 2'd0;
        end else begin
            if (w_oq_push) begin
                r_oq_pc[r_oq_wr] <= w_pcq_head;
                r_oq_ir[r_oq_wr] <= im_data_i;
                r_oq_wr          <= ~r_oq_wr;
            end
            if (w_oq_pop) begin
                r_oq_rd <= ~r_oq_rd;
            end
            case ({w_oq_push, w_oq_pop})
                2'b10:   r_oq_cnt <= r_oq_cnt + 2'd1;
                2'b01:   r_oq_cnt <= r_oq_cnt - 2'd1;
                default: r_oq_cnt <= r_oq_cnt;
            endcase
        end
    end

    // discard counter: grows by the flushed in-flight count, shrinks per discarded response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_drop_cnt <= 2'd0;
        end else if (x_bra_i) begin
            r_drop_cnt <= w_drop_sum[1:0];
        end else if (w_resp_drop) begin
            r_drop_cnt <= r_drop_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
// tb/tb_rv_fetch.sv - directed and random self-checking bench for rv_fetch
module tb_rv_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic        im_busy_i = 1'b0;
    logic [31:0] im_data_i = 32'd0;
    logic        im_valid_i = 1'b0;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;
    logic        f_stall_i = 1'b0;
    logic        x_bra_i = 1'b0;
    logic [31:0] x_pc_bra_i = 32'd0;

    int vecs = 0;
    int errs = 0;

    rv_fetch #(.g_RESET_VECTOR(32'h0000_0100)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .im_addr_o  (im_addr_o),
        .im_rd_o    (im_rd_o),
        .im_busy_i  (im_busy_i),
        .im_data_i  (im_data_i),
        .im_valid_i (im_valid_i),
        .f_ir_o     (f_ir_o),
        .f_pc_o     (f_pc_o),
        .f_valid_o  (f_valid_o),
        .f_stall_i  (f_stall_i),
        .x_bra_i    (x_bra_i),
        .x_pc_bra_i (x_pc_bra_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // in-order instruction memory with a fixed latency of lat cycles
    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } req_t;
    req_t        mq[$];
    int unsigned mcyc = 0;
    int unsigned lat = 1;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mq.delete();
            im_valid_i <= 1'b0;
            im_data_i  <= 32'd0;
        end else begin
            mcyc = mcyc + 1;
            if (im_rd_o && !im_busy_i) begin
                mq.push_back('{due: mcyc + lat - 1, addr: im_addr_o});
            end
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                im_valid_i <= 1'b1;
                im_data_i  <= memw(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                im_valid_i <= 1'b0;
            end
        end
    end

    task automatic do_reset(input int unsigned l);
        rst_n_i    = 1'b0;
        x_bra_i    = 1'b0;
        x_pc_bra_i = 32'd0;
        f_stall_i  = 1'b0;
        im_busy_i  = 1'b0;
        lat        = l;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        lat     = 1;
        repeat (2) @(negedge clk_i);
        vecs++; if (f_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", f_valid_o); end
        vecs++; if (f_ir_o !== 32'd0) begin errs++; $display("FAIL rst_ir got %h want 0", f_ir_o); end
        vecs++; if (f_pc_o !== 32'd0) begin errs++; $display("FAIL rst_pc got %h want 0", f_pc_o); end
        vecs++; if (im_rd_o !== 1'b0) begin errs++; $display("FAIL rst_rd got %b want 0", im_rd_o); end
        vecs++; if (im_addr_o !== 32'h100) begin errs++; $display("FAIL rst_addr got %h want 00000100", im_addr_o); end
        rst_n_i = 1'b1;
        #1;
        vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, 32'h100}) begin errs++; $display("FAIL rst_first_req got %b/%h want 1/00000100", im_rd_o, im_addr_o); end
    endtask

    task automatic test_sequential;
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            e = 32'h100 + 32'(4 * c);
            vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, e}) begin errs++; $display("FAIL seq_req c=%0d got %b/%h want 1/%h", c, im_rd_o, im_addr_o, e); end
            vecs++; if (f_valid_o !== (c >= 2)) begin errs++; $display("FAIL seq_valid c=%0d got %b want %b", c, f_valid_o, c >= 2); end
            if (c >= 2) begin
                e = 32'h100 + 32'(4 * (c - 2));
                vecs++; if (f_pc_o !== e) begin errs++; $display("FAIL seq_pc c=%0d got %h want %h", c, f_pc_o, e); end
                vecs++; if (f_ir_o !== memw(e)) begin errs++; $display("FAIL seq_ir c=%0d got %h want %h", c, f_ir_o, memw(e)); end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] ep;
        logic [31:0] ea;
        logic        er;
        do_reset(1);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk_i);
            f_stall_i = (c >= 4 && c <= 8);
            #1;
            if (c < 4)       begin er = 1'b1; ea = 32'h100 + 32'(4 * c); end
            else if (c <= 8) begin er = 1'b0; ea = 32'h110; end
            else             begin er = 1'b1; ea = 32'h110 + 32'(4 * (c - 9)); end
            vecs++; if (im_rd_o !== er) begin errs++; $display("FAIL stall_rd c=%0d got %b want %b", c, im_rd_o, er); end
            if (er) begin
                vecs++; if (im_addr_o !== ea) begin errs++; $display("FAIL stall_addr c=%0d got %h want %h", c, im_addr_o, ea); end
            end
            if (c >= 2) begin
                if (c <= 4)      ep = 32'h100 + 32'(4 * (c - 2));
                else if (c <= 8) ep = 32'h108;
                else             ep = 32'h108 + 32'(4 * (c - 9));
                vecs++; if ({f_valid_o, f_pc_o} !== {1'b1, ep}) begin errs++; $display("FAIL stall_pc c=%0d got %b/%h want 1/%h", c, f_valid_o, f_pc_o, ep); end
                vecs++; if (f_ir_o !== memw(ep)) begin errs++; $display("FAIL stall_ir c=%0d got %h want %h", c, f_ir_o, memw(ep)); end
            end
        end
        f_stall_i = 1'b0;
    endtask

    task automatic test_redirect;
        logic [31:0] ep;
        ep = 32'h200;
        do_reset(2);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk_i);
            x_bra_i    = (c == 2);
            x_pc_bra_i = 32'h200;
            #1;
            if (c < 2) begin
                vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, 32'h100 + 32'(4 * c)}) begin errs++; $display("FAIL bra_pre_req c=%0d got %b/%h", c, im_rd_o, im_addr_o); end
            end
            if (c == 2) begin
                vecs++; if (im_rd_o !== 1'b0) begin errs++; $display("FAIL bra_rd_blocked got %b want 0", im_rd_o); end
            end
            if (c == 3) begin
                vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, 32'h200}) begin errs++; $display("FAIL bra_target_req got %b/%h want 1/00000200", im_rd_o, im_addr_o); end
            end
            if (c >= 3 && c <= 5) begin
                vecs++; if (f_valid_o !== 1'b0) begin errs++; $display("FAIL bra_gap c=%0d got %b want 0", c, f_valid_o); end
            end
            if (c == 6) begin
                vecs++; if (f_valid_o !== 1'b1) begin errs++; $display("FAIL bra_first_valid got %b want 1", f_valid_o); end
            end
            if (c >= 6 && f_valid_o) begin
                vecs++; if (f_pc_o !== ep) begin errs++; $display("FAIL bra_pc c=%0d got %h want %h", c, f_pc_o, ep); end
                vecs++; if (f_ir_o !== memw(ep)) begin errs++; $display("FAIL bra_ir c=%0d got %h want %h", c, f_ir_o, memw(ep)); end
                ep = ep + 32'd4;
            end
        end
        x_bra_i = 1'b0;
    endtask

    task automatic test_redirect_same_cycle;
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk_i);
            x_bra_i    = (c == 3);
            x_pc_bra_i = 32'h303;
            #1;
            if (c == 3) begin
                vecs++; if (im_rd_o !== 1'b0) begin errs++; $display("FAIL sc_rd_blocked got %b want 0", im_rd_o); end
            end
            if (c == 4) begin
                vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, 32'h300}) begin errs++; $display("FAIL sc_target_req got %b/%h want 1/00000300", im_rd_o, im_addr_o); end
            end
            if (c == 4 || c == 5) begin
                vecs++; if (f_valid_o !== 1'b0) begin errs++; $display("FAIL sc_gap c=%0d got %b want 0", c, f_valid_o); end
            end
            if (c == 6 || c == 7) begin
                vecs++; if ({f_valid_o, f_pc_o} !== {1'b1, 32'h300 + 32'(4 * (c - 6))}) begin errs++; $display("FAIL sc_pc c=%0d got %b/%h", c, f_valid_o, f_pc_o); end
                vecs++; if (f_ir_o !== memw(32'h300 + 32'(4 * (c - 6)))) begin errs++; $display("FAIL sc_ir c=%0d got %h", c, f_ir_o); end
            end
        end
        x_bra_i = 1'b0;
    endtask

    task automatic test_wrap_reset;
        logic [31:0] e;
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk_i);
            x_bra_i    = (c == 3);
            x_pc_bra_i = 32'hFFFF_FFF8;
            #1;
            if (c >= 4 && c <= 6) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (c - 4));
                vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, e}) begin errs++; $display("FAIL wrap_req c=%0d got %b/%h want 1/%h", c, im_rd_o, im_addr_o, e); end
            end
            if (c >= 6 && c <= 8) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (c - 6));
                vecs++; if ({f_valid_o, f_pc_o} !== {1'b1, e}) begin errs++; $display("FAIL wrap_pc c=%0d got %b/%h want 1/%h", c, f_valid_o, f_pc_o, e); end
                vecs++; if (f_ir_o !== memw(e)) begin errs++; $display("FAIL wrap_ir c=%0d got %h want %h", c, f_ir_o, memw(e)); end
            end
        end
        x_bra_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        vecs++; if ({f_valid_o, f_pc_o, f_ir_o} !== 65'd0) begin errs++; $display("FAIL async_rst_out got %b/%h/%h want 0/0/0", f_valid_o, f_pc_o, f_ir_o); end
        vecs++; if (im_rd_o !== 1'b0) begin errs++; $display("FAIL async_rst_rd got %b want 0", im_rd_o); end
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        vecs++; if ({im_rd_o, im_addr_o} !== {1'b1, 32'h100}) begin errs++; $display("FAIL restart_req got %b/%h want 1/00000100", im_rd_o, im_addr_o); end
        repeat (2) @(negedge clk_i);
        #1;
        vecs++; if ({f_valid_o, f_pc_o, f_ir_o} !== {1'b1, 32'h100, memw(32'h100)}) begin errs++; $display("FAIL restart_out got %b/%h/%h want 1/00000100/%h", f_valid_o, f_pc_o, f_ir_o, memw(32'h100)); end
    endtask

    task automatic test_random;
        logic [31:0] ep;
        int          got;
        int          cyc;
        ep  = 32'h100;
        got = 0;
        cyc = 0;
        do_reset(1);
        while (got < 10000 && cyc < 60000) begin
            im_busy_i = 1'($urandom_range(0, 1));
            f_stall_i = ($urandom_range(0, 3) == 0);
            #1;
            if (f_valid_o && !f_stall_i) begin
                vecs++; if (f_pc_o !== ep) begin errs++; $display("FAIL rnd_pc n=%0d got %h want %h", got, f_pc_o, ep); end
                vecs++; if (f_ir_o !== memw(f_pc_o)) begin errs++; $display("FAIL rnd_ir n=%0d got %h want %h", got, f_ir_o, memw(f_pc_o)); end
                ep  = ep + 32'd4;
                got = got + 1;
            end
            cyc = cyc + 1;
            @(negedge clk_i);
        end
        vecs++; if (got < 10000) begin errs++; $display("FAIL rnd_budget got %0d instructions want 10000", got); end
        im_busy_i = 1'b0;
        f_stall_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_redirect;
        test_redirect_same_cycle;
        test_wrap_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
